instr_fetch: RTL and testbench

Instruction fetch stage for the multi-cycle RV32I core. Issues word reads to instruction memory over a req/ack handshake, tags each returned word with its 12-bit PC, and buffers it in a small FIFO. The decode/control FSM downstream consumes words through a valid/ready interface. A redirect port accepts branch/jump targets, which flush buffered and in-flight fetches.

---
 rtl/instr_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_instr_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage - imem req/ack master feeding a PC-tagged instruction FIFO, with redirect flush.
// Optional feature macro IFETCH_MISALIGN_CHK_EN: misaligned redirects set misalign_err and halt fetching.
module instr_fetch #(
    parameter int unsigned       ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              misalign_err
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0]       data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {
        ST_STALL = 2'd0,
        ST_REQ   = 2'd1,
        ST_DROP  = 2'd2
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        ST_HALT  = 2'd3
`endif
    } state_t;

`ifdef IFETCH_MISALIGN_CHK_EN
    localparam state_t ST_MIS = ST_HALT;
`else
    localparam state_t ST_MIS = ST_STALL;
`endif

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_pending, w_pending_nxt;
    logic [ADDR_W-1:0] r_imem_addr, w_imem_addr_nxt;
    logic              r_imem_req, w_imem_req_nxt;
    logic              r_halt_pend, w_halt_pend_nxt;
    entry_t            r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic              r_instr_valid;
    logic              w_push, w_pop, w_misalign;
    logic [ADDR_W-1:0] w_target;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic r_misalign_err, w_misalign_err_nxt;
    assign w_target   = redirect_addr;
    assign w_misalign = redirect_valid && (redirect_addr[1:0] != 2'b00);
`else
    logic w_unused_addr_lo;
    assign w_target         = {redirect_addr[ADDR_W-1:2], 2'b00};
    assign w_misalign       = 1'b0;
    assign w_unused_addr_lo = ^redirect_addr[1:0];
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state, fetch PC and FIFO occupancy; redirect takes priority over everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_pending_nxt   = r_pending;
        w_halt_pend_nxt = r_halt_pend;
        w_push          = 1'b0;
        w_pop           = r_instr_valid && instr_ready && !redirect_valid;
`ifdef IFETCH_MISALIGN_CHK_EN
        w_misalign_err_nxt = redirect_valid ? w_misalign : r_misalign_err;
`endif
        unique case (r_state)
            ST_REQ: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        if (w_misalign) w_state_nxt = ST_MIS;
                        else            w_fetch_pc_nxt = w_target;
                    end else begin
                        w_state_nxt     = ST_DROP;
                        w_halt_pend_nxt = w_misalign;
                        if (!w_misalign) w_pending_nxt = w_target;
                    end
                end else if (imem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
                end
            end
            ST_STALL: begin
                if (redirect_valid) begin
                    if (w_misalign) begin
                        w_state_nxt = ST_MIS;
                    end else begin
                        w_state_nxt    = ST_REQ;
                        w_fetch_pc_nxt = w_target;
                    end
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    w_halt_pend_nxt = 1'b0;
                    if (redirect_valid ? w_misalign : r_halt_pend) begin
                        w_state_nxt = ST_MIS;
                    end else begin
                        w_state_nxt    = ST_REQ;
                        w_fetch_pc_nxt = redirect_valid ? w_target : r_pending;
                    end
                end else if (redirect_valid) begin
                    w_halt_pend_nxt = w_misalign;
                    if (!w_misalign) w_pending_nxt = w_target;
                end
            end
`ifdef IFETCH_MISALIGN_CHK_EN
            ST_HALT: begin
                if (redirect_valid && !w_misalign) begin
                    w_state_nxt    = ST_REQ;
                    w_fetch_pc_nxt = w_target;
                end
            end
`endif
            default: w_state_nxt = ST_STALL;
        endcase

        w_count_nxt = redirect_valid ? '0 : r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        // Issue only while the FIFO can take the returning word.
        if (w_state_nxt == ST_REQ && w_count_nxt >= CNT_W'(FIFO_DEPTH))
            w_state_nxt = ST_STALL;
        else if (w_state_nxt == ST_STALL && w_count_nxt < CNT_W'(FIFO_DEPTH))
            w_state_nxt = ST_REQ;

        w_imem_req_nxt  = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_DROP);
        w_imem_addr_nxt = (w_state_nxt == ST_DROP) ? r_imem_addr : w_fetch_pc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_STALL;
            r_fetch_pc  <= RESET_PC;
            r_pending   <= RESET_PC;
            r_halt_pend <= 1'b0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_pending   <= w_pending_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            r_imem_req  <= w_imem_req_nxt;
            r_imem_addr <= w_imem_addr_nxt;
        end
    end

    // Instruction buffer: redirect resets pointers, which also drops any same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_fifo[i] <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            r_instr_valid <= (w_count_nxt != '0);
            if (redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo[r_wr_ptr] <= entry_t'{data: imem_rdata, pc: r_fetch_pc};
                    r_wr_ptr         <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_misalign_err <= 1'b0;
        else        r_misalign_err <= w_misalign_err_nxt;
    end
    assign misalign_err = r_misalign_err;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instr_valid = r_instr_valid;
    assign instr_data  = r_fifo[r_rd_ptr].data;
    assign instr_pc    = r_fifo[r_rd_ptr].pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch (memory returns addr+0x100, word/address scoreboards).
// Also exercises IFETCH_MISALIGN_CHK_EN behaviour when that macro is defined.
module tb_instr_fetch;
    localparam int unsigned ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_addr = '0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [31:0]       instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              misalign_err;

    instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(12'h000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Memory model: ack after 'lat' wait cycles, data = address + 0x100.
    int lat = 0;
    int wait_cnt = 0;
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = 32'(imem_addr) + 32'h100;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      wait_cnt <= 0;
        else if (!imem_req || imem_ack)  wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
    end

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       data;
    } exp_t;

    typedef struct {
        logic              ready;
        logic              exp_req;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_valid;
        logic [ADDR_W-1:0] exp_pc;
        logic [31:0]       exp_data;
    } vec_t;

    logic [ADDR_W-1:0] exp_addr_q [$];
    exp_t              exp_instr_q [$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'(a) + 32'h100;
    endfunction

    task automatic expect_seq(input logic [ADDR_W-1:0] start, input int n_addr, input int n_instr);
        for (int i = 0; i < n_addr; i++) exp_addr_q.push_back(start + ADDR_W'(4 * i));
        for (int i = 0; i < n_instr; i++) begin
            exp_t e;
            e.pc   = start + ADDR_W'(4 * i);
            e.data = mem_word(e.pc);
            exp_instr_q.push_back(e);
        end
    endtask

    // Scoreboards: acked request addresses and consumed instruction words, in order.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && imem_req && imem_ack && exp_addr_q.size() > 0)
            chk("sb_imem_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
        if (rst_n && instr_valid && instr_ready && !redirect_valid && exp_instr_q.size() > 0) begin
            e = exp_instr_q.pop_front();
            chk("sb_instr_pc", 32'(instr_pc), 32'(e.pc));
            chk("sb_instr_data", instr_data, e.data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_addr_q.size() != 0 || exp_instr_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_addr_q", 32'(exp_addr_q.size()), 32'd0);
        chk("drain_instr_q", 32'(exp_instr_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_instr_q.delete();
    endtask

    task automatic do_reset(input int latency);
        step();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        lat            = latency;
        @(negedge clk);
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst imem_addr", 32'(imem_addr), 32'h000);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst instr_data", instr_data, 32'd0);
        chk("rst instr_pc", 32'(instr_pc), 32'd0);
        chk("rst misalign_err", 32'(misalign_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        int   found;
        // ready, req, addr, valid, pc, data  (row 0 = first cycle after reset release)
        tbl[0]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 32'h000};
        tbl[1]  = '{1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 32'h000};
        tbl[2]  = '{1'b0, 1'b1, 12'h004, 1'b1, 12'h000, 32'h100};
        tbl[3]  = '{1'b0, 1'b0, 12'h008, 1'b1, 12'h000, 32'h100};
        tbl[4]  = '{1'b0, 1'b0, 12'h008, 1'b1, 12'h000, 32'h100};
        tbl[5]  = '{1'b1, 1'b0, 12'h008, 1'b1, 12'h000, 32'h100};
        tbl[6]  = '{1'b1, 1'b1, 12'h008, 1'b1, 12'h004, 32'h104};
        tbl[7]  = '{1'b1, 1'b1, 12'h00C, 1'b1, 12'h008, 32'h108};
        tbl[8]  = '{1'b1, 1'b1, 12'h010, 1'b1, 12'h00C, 32'h10C};
        tbl[9]  = '{1'b1, 1'b1, 12'h014, 1'b1, 12'h010, 32'h110};
        tbl[10] = '{1'b1, 1'b1, 12'h018, 1'b1, 12'h014, 32'h114};

        // Zero-wait memory: fill to 2 words with ready low, then drain at one word per cycle.
        do_reset(0);
        expect_seq(12'h000, 7, 6);
        for (int i = 0; i < 11; i++) begin
            instr_ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("t1[%0d] imem_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
            chk($sformatf("t1[%0d] imem_addr", i), 32'(imem_addr), 32'(tbl[i].exp_addr));
            chk($sformatf("t1[%0d] instr_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("t1[%0d] instr_pc", i), 32'(instr_pc), 32'(tbl[i].exp_pc));
            chk($sformatf("t1[%0d] instr_data", i), instr_data, tbl[i].exp_data);
            step();
        end
        wait_drain(20);

        // 3-cycle latency; redirect while 0x010 is outstanding drops that word.
        do_reset(3);
        instr_ready = 1'b1;
        expect_seq(12'h000, 5, 4);
        expect_seq(12'h040, 2, 2);
        found = 0;
        for (int n = 0; n < 100 && found == 0; n++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 12'h010) found = 1;
        end
        chk("t2 reach 0x010", 32'(found), 32'd1);
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 12'h040;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t2 drop imem_req", 32'(imem_req), 32'd1);
        chk("t2 drop addr held", 32'(imem_addr), 32'h010);
        chk("t2 drop instr_valid", 32'(instr_valid), 32'd0);
        wait_drain(100);

        // Redirect coinciding with the ack of 0x020 while the FIFO holds 0x01C.
        do_reset(0);
        instr_ready = 1'b1;
        expect_seq(12'h000, 9, 7);
        expect_seq(12'h080, 2, 2);
        found = 0;
        for (int n = 0; n < 50 && found == 0; n++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 12'h01C) found = 1;
        end
        chk("t3 reach 0x01C", 32'(found), 32'd1);
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 12'h080;
        @(negedge clk);
        chk("t3 ack addr", 32'(imem_addr), 32'h020);
        chk("t3 fifo nonempty", 32'(instr_valid), 32'd1);
        chk("t3 head pc", 32'(instr_pc), 32'h01C);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3 flushed valid", 32'(instr_valid), 32'd0);
        chk("t3 new req", 32'(imem_req), 32'd1);
        chk("t3 new addr", 32'(imem_addr), 32'h080);
        wait_drain(50);

        // Redirect from STALL to 0xFF8 and wrap 0xFFC -> 0x000.
        do_reset(0);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 12'hFF8;
        expect_seq(12'hFF8, 4, 3);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4 req N+1", 32'(imem_req), 32'd1);
        chk("t4 addr N+1", 32'(imem_addr), 32'hFF8);
        chk("t4 valid N+1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("t4 addr 0xFFC", 32'(imem_addr), 32'hFFC);
        chk("t4 valid N+2", 32'(instr_valid), 32'd1);
        chk("t4 pc N+2", 32'(instr_pc), 32'hFF8);
        @(negedge clk);
        chk("t4 wrap addr", 32'(imem_addr), 32'h000);
        wait_drain(20);

        // Misaligned redirect target 0x042.
        do_reset(0);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 12'h042;
`ifdef IFETCH_MISALIGN_CHK_EN
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5 halt req[%0d]", i), 32'(imem_req), 32'd0);
            chk($sformatf("t5 halt err[%0d]", i), 32'(misalign_err), 32'd1);
        end
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 12'h044;
        expect_seq(12'h044, 2, 2);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5 resume req", 32'(imem_req), 32'd1);
        chk("t5 resume addr", 32'(imem_addr), 32'h044);
        chk("t5 err cleared", 32'(misalign_err), 32'd0);
`else
        expect_seq(12'h040, 2, 2);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5 req", 32'(imem_req), 32'd1);
        chk("t5 forced align addr", 32'(imem_addr), 32'h040);
        chk("t5 err tied low", 32'(misalign_err), 32'd0);
`endif
        wait_drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
